// File: rtl/risc_pkg.sv
// risc_pkg: definitions shared by the fetch stage and its IF/ID register.
//   INSTR_W / ADDR_W : default instruction width and program-memory address width
//   OPC_HALT         : 7-bit opcode that stops fetch
//   NOP_INSTR        : bubble word placed in IF/ID on a flush
//   fetch_state_e    : fetch FSM states
//   ifid_op_e        : per-cycle action applied to the IF/ID register
package risc_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 12;

    localparam logic [6:0]  OPC_HALT  = 7'b1111111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [0:0] {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_LOAD  = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_op_e;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register holding {instruction, pc, valid}.
//   clk, rst    : clock, synchronous active-high reset
//   op          : HOLD keeps contents, LOAD captures instr_in/pc_in as valid,
//                 FLUSH inserts a NOP bubble while keeping the stored pc
//   instr_in    : instruction to capture
//   pc_in       : address instr_in was fetched from
//   instr/pc/valid : registered outputs to decode
module ifid_reg
    import risc_pkg::*;
#(
    parameter int INSTR_W = risc_pkg::INSTR_W,
    parameter int ADDR_W  = risc_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  ifid_op_e           op,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        unique case (op)
            IFID_LOAD: begin
                instr_d = instr_in;
                pc_d    = pc_in;
                valid_d = 1'b1;
            end
            IFID_FLUSH: begin
                // The pc field is left alone: a bubble keeps the last real address.
                instr_d = INSTR_W'(NOP_INSTR);
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) begin
            instr_q <= INSTR_W'(NOP_INSTR);
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage. Owns the PC, drives program memory, and
// feeds the IF/ID register. Handles stalls, branch redirects and halt.
//   clk, rst     : clock, synchronous active-high reset
//   program_addr : word address to program memory (the PC register)
//   instruction  : asynchronous read data for program_addr
//   stall        : decode cannot accept; hold PC and IF/ID
//   redirect     : taken branch/jump from execute, overrides stall
//   redirect_pc  : redirect target word address
//   ifid_instr / ifid_pc / ifid_valid : IF/ID register outputs
//   halted       : fetch has stopped on a halt instruction
module instruction_fetch
    import risc_pkg::*;
#(
    parameter int INSTR_W = risc_pkg::INSTR_W,
    parameter int ADDR_W  = risc_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  program_addr,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid,
    output logic               halted
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    fetch_state_e      state_q, state_d;
    ifid_op_e          ifid_op;

    // Priority: redirect > stall > halt detect > normal fetch (rst handled in the flops).
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        ifid_op = IFID_HOLD;
        if (redirect) begin
            // A redirect also cancels a halt that was fetched on the wrong path.
            pc_d    = redirect_pc;
            state_d = FS_RUN;
            ifid_op = IFID_FLUSH;
        end else if (!stall) begin
            if (state_q == FS_RUN) begin
                ifid_op = IFID_LOAD;
                if (instruction[6:0] == OPC_HALT) begin
                    state_d = FS_HALTED;
                end else begin
                    pc_d = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
                end
            end else begin
                // Halted: deliver the halt word once, then bubbles.
                ifid_op = IFID_FLUSH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            state_q <= FS_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    ifid_reg #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .op       (ifid_op),
        .instr_in (instruction),
        .pc_in    (pc_q),
        .instr    (ifid_instr),
        .pc       (ifid_pc),
        .valid    (ifid_valid)
    );

    assign program_addr = pc_q;
    assign halted       = (state_q == FS_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for instruction_fetch.
// A behavioural program memory answers program_addr asynchronously; inputs
// change 1 time unit after a rising edge and outputs are checked there too.
module tb_instruction_fetch;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 12;

    localparam logic [31:0] W_ADDI2 = 32'h0060_0113;  // addi x2, x0, 6
    localparam logic [31:0] W_ADDI3 = 32'h00a0_0193;  // addi x3, x0, 10
    localparam logic [31:0] W_NOP   = 32'h0000_0000;
    localparam logic [31:0] W_ADD   = 32'h0031_0233;
    localparam logic [31:0] W_SUB   = 32'h4031_02b3;
    localparam logic [31:0] W_AND   = 32'h0031_7333;
    localparam logic [31:0] W_OR    = 32'h0031_63b3;
    localparam logic [31:0] W_XOR   = 32'h0031_4433;
    localparam logic [31:0] W_HALT  = 32'h0000_007f;
    localparam logic [31:0] W_TOP   = 32'h0010_0093;  // word at 4095

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  program_addr;
    logic [INSTR_W-1:0] instruction;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc;
    logic               ifid_valid;
    logic               halted;

    logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0]        prog [0:9];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign instruction = mem[program_addr];

    instruction_fetch #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .program_addr (program_addr),
        .instruction  (instruction),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_valid   (ifid_valid),
        .halted       (halted)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state of the stage in one call.
    task automatic expect_all(input string tag, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] instr, input logic [ADDR_W-1:0] pc,
                              input logic valid, input logic hlt);
        check({tag, ".program_addr"}, 64'(program_addr), 64'(addr));
        check({tag, ".ifid_instr"},   64'(ifid_instr),   64'(instr));
        check({tag, ".ifid_pc"},      64'(ifid_pc),      64'(pc));
        check({tag, ".ifid_valid"},   64'(ifid_valid),   64'(valid));
        check({tag, ".halted"},       64'(halted),       64'(hlt));
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = W_NOP;
        prog[0] = W_ADDI2; prog[1] = W_ADDI3; prog[2] = W_NOP; prog[3] = W_NOP;
        prog[4] = W_ADD;   prog[5] = W_SUB;   prog[6] = W_AND; prog[7] = W_OR;
        prog[8] = W_XOR;   prog[9] = W_HALT;
        for (int i = 0; i < 10; i++) mem[i] = prog[i];
        mem[4095] = W_TOP;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        step();
        expect_all("reset", 12'd0, W_NOP, 12'd0, 1'b0, 1'b0);

        // Straight-line run to the halt word.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("run%0d.ifid_pc", i), 64'(ifid_pc), 64'(i));
            check($sformatf("run%0d.instr", i), 64'(ifid_instr), 64'(prog[i]));
            check($sformatf("run%0d.valid", i), 64'(ifid_valid), 64'd1);
            check($sformatf("run%0d.halted", i), 64'(halted), (i == 9) ? 64'd1 : 64'd0);
        end
        check("halt.pc_hold", 64'(program_addr), 64'd9);
        step();
        expect_all("halted1", 12'd9, W_NOP, 12'd9, 1'b0, 1'b1);
        step();
        expect_all("halted2", 12'd9, W_NOP, 12'd9, 1'b0, 1'b1);

        // Redirect out of HALTED.
        redirect = 1'b1; redirect_pc = 12'd4;
        step();
        expect_all("unhalt", 12'd4, W_NOP, 12'd9, 1'b0, 1'b0);
        redirect = 1'b0;
        step();
        expect_all("resume4", 12'd5, W_ADD, 12'd4, 1'b1, 1'b0);

        // Three-cycle stall with ADD in IF/ID.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_all($sformatf("stall%0d", i), 12'd5, W_ADD, 12'd4, 1'b1, 1'b0);
        end
        stall = 1'b0;
        step();
        expect_all("unstall", 12'd6, W_SUB, 12'd5, 1'b1, 1'b0);
        step();
        expect_all("fetch6", 12'd7, W_AND, 12'd6, 1'b1, 1'b0);

        // Branch back to 2 while ifid_pc = 6.
        redirect = 1'b1; redirect_pc = 12'd2;
        step();
        expect_all("redir2", 12'd2, W_NOP, 12'd6, 1'b0, 1'b0);
        redirect = 1'b0;
        step();
        expect_all("target2", 12'd3, W_NOP, 12'd2, 1'b1, 1'b0);

        // Run to halt again, then stall while halted: halt word stays put.
        for (int i = 3; i < 10; i++) step();
        expect_all("halt_again", 12'd9, W_HALT, 12'd9, 1'b1, 1'b1);
        stall = 1'b1;
        step();
        expect_all("halt_stall", 12'd9, W_HALT, 12'd9, 1'b1, 1'b1);

        // Redirect + stall together, to the top of memory.
        redirect = 1'b1; redirect_pc = 12'd4095;
        step();
        expect_all("redir_stall", 12'd4095, W_NOP, 12'd9, 1'b0, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        step();
        expect_all("top", 12'd0, W_TOP, 12'd4095, 1'b1, 1'b0);
        step();
        expect_all("wrap", 12'd1, W_ADDI2, 12'd0, 1'b1, 1'b0);

        // Redirect + stall in RUN flushes the stalled instruction.
        redirect = 1'b1; stall = 1'b1; redirect_pc = 12'd8;
        step();
        expect_all("run_redir_stall", 12'd8, W_NOP, 12'd0, 1'b0, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        step();
        expect_all("target8", 12'd9, W_XOR, 12'd8, 1'b1, 1'b0);

        // Reset mid-stream overrides a redirect.
        rst = 1'b1; redirect = 1'b1; redirect_pc = 12'd7;
        step();
        expect_all("mid_reset", 12'd0, W_NOP, 12'd0, 1'b0, 1'b0);
        rst = 1'b0; redirect = 1'b0;
        step();
        expect_all("post_reset", 12'd1, W_ADDI2, 12'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
